// File: rtl/crf_lite_master_if.sv
// AXI4-Lite bus bundle between the register-file command master and its slave.
interface crf_lite_master_if #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32
);
    logic                        awvalid;
    logic                        awready;
    logic [AXI_ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]                  awprot;
    logic                        wvalid;
    logic                        wready;
    logic [AXI_DATA_WIDTH-1:0]   wdata;
    logic [AXI_DATA_WIDTH/8-1:0] wstrb;
    logic                        bvalid;
    logic                        bready;
    logic [1:0]                  bresp;
    logic                        arvalid;
    logic                        arready;
    logic [AXI_ADDR_WIDTH-1:0]   araddr;
    logic [2:0]                  arprot;
    logic                        rvalid;
    logic                        rready;
    logic [AXI_DATA_WIDTH-1:0]   rdata;
    logic [1:0]                  rresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/crf_lite_master.sv
// Single-outstanding AXI4-Lite master: turns one host register command into
// one AXI4-Lite write or read and hands back a single completion record.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for a host command, cmd_ready high
// WR_REQ    | AW and W offered; each valid drops after its own handshake
// WR_RESP   | both AW and W done, waiting for B
// RD_REQ    | AR offered, waiting for arready
// RD_DATA   | waiting for R
// RSP       | completion held on rsp_* until the host takes it
module crf_lite_master #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_wr,
    input  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic                        rsp_wr,
    output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                  rsp_resp,
    output logic                        busy,
    crf_lite_master_if.master           m_axi
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR_REQ  = 3'd1;
    localparam logic [2:0] S_WR_RESP = 3'd2;
    localparam logic [2:0] S_RD_REQ  = 3'd3;
    localparam logic [2:0] S_RD_DATA = 3'd4;
    localparam logic [2:0] S_RSP     = 3'd5;

    logic [2:0]                  state;
    logic [AXI_ADDR_WIDTH-1:0]   addr_q;
    logic [AXI_DATA_WIDTH-1:0]   wdata_q;
    logic [AXI_DATA_WIDTH/8-1:0] wstrb_q;
    logic                        awvalid_q;
    logic                        wvalid_q;
    logic                        arvalid_q;
    logic                        aw_ok;
    logic                        w_ok;

    // A channel counts as finished once its valid has dropped or it handshakes now.
    assign aw_ok = !awvalid_q || m_axi.awready;
    assign w_ok  = !wvalid_q  || m_axi.wready;

    // cmd_ready is gated by rst so it reads low for the whole reset window.
    assign cmd_ready = (state == S_IDLE) && !rst;
    assign busy      = (state != S_IDLE);
    assign rsp_valid = (state == S_RSP);

    assign m_axi.awvalid = awvalid_q;
    assign m_axi.awaddr  = addr_q;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = wstrb_q;
    assign m_axi.bready  = (state == S_WR_RESP);
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.araddr  = addr_q;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.rready  = (state == S_RD_DATA);

    // Sequencer: command capture, AXI valid tracking and completion capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rsp_wr    <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= 2'b00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        addr_q  <= cmd_addr;
                        wdata_q <= cmd_wdata;
                        wstrb_q <= cmd_wstrb;
                        if (cmd_wr) begin
                            state     <= S_WR_REQ;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                        end else begin
                            state     <= S_RD_REQ;
                            arvalid_q <= 1'b1;
                        end
                    end
                end
                S_WR_REQ: begin
                    if (awvalid_q && m_axi.awready) awvalid_q <= 1'b0;
                    if (wvalid_q && m_axi.wready)   wvalid_q  <= 1'b0;
                    if (aw_ok && w_ok)              state     <= S_WR_RESP;
                end
                S_WR_RESP: begin
                    if (m_axi.bvalid) begin
                        rsp_resp  <= m_axi.bresp;
                        rsp_rdata <= '0;
                        rsp_wr    <= 1'b1;
                        state     <= S_RSP;
                    end
                end
                S_RD_REQ: begin
                    if (m_axi.arready) begin
                        arvalid_q <= 1'b0;
                        state     <= S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (m_axi.rvalid) begin
                        rsp_rdata <= m_axi.rdata;
                        rsp_resp  <= m_axi.rresp;
                        rsp_wr    <= 1'b0;
                        state     <= S_RSP;
                    end
                end
                S_RSP: begin
                    if (rsp_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crf_lite_master.sv
// Directed and randomized checks of crf_lite_master against a word-memory
// reference model and a latency-configurable AXI4-Lite slave.
module tb_crf_lite_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_wr = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_wr;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        busy;

    always #5 clk = ~clk;

    crf_lite_master_if #(.AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(32)) bus ();

    crf_lite_master #(.AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wr(rsp_wr),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .busy(busy),
        .m_axi(bus)
    );

    // slave-side drive, plus injectors for stray B/R beats
    logic        s_awready = 0, s_wready = 0, s_bvalid = 0, s_arready = 0, s_rvalid = 0;
    logic [1:0]  s_bresp = 0, s_rresp = 0;
    logic [31:0] s_rdata = 0;
    logic        spur_bvalid = 0, spur_rvalid = 0;
    logic [31:0] spur_rdata = 0;

    assign bus.awready = s_awready;
    assign bus.wready  = s_wready;
    assign bus.bvalid  = s_bvalid | spur_bvalid;
    assign bus.bresp   = spur_bvalid ? 2'b11 : s_bresp;
    assign bus.arready = s_arready;
    assign bus.rvalid  = s_rvalid | spur_rvalid;
    assign bus.rdata   = spur_rvalid ? spur_rdata : s_rdata;
    assign bus.rresp   = spur_rvalid ? 2'b11 : s_rresp;

    int lat_aw = 0, lat_w = 0, lat_b = 0, lat_ar = 0, lat_r = 0;
    logic [1:0] cfg_resp = 2'b00;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] slv_mem [logic [31:0]];
    logic [31:0] last_rdata = 0;
    logic [1:0]  last_resp = 0;
    logic        last_wr = 0;

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    function automatic void ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] mask;
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        ref_mem[a] = (ref_read(a) & ~mask) | (d & mask);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Slave: acts on falling edges, so its readies/valids are stable across the rising edge.
    initial begin : slave
        bit aw_f, w_f, b_f, ar_f, r_f, aw_d, w_d, ar_d;
        int c_aw, c_w, c_b, c_ar, c_r;
        logic [31:0] a_aw, d_w, a_ar, cur;
        logic [3:0]  s_w;
        aw_f = 0; w_f = 0; b_f = 0; ar_f = 0; r_f = 0; aw_d = 0; w_d = 0; ar_d = 0;
        c_aw = 0; c_w = 0; c_b = 0; c_ar = 0; c_r = 0;
        a_aw = 0; d_w = 0; a_ar = 0; s_w = 0; cur = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                aw_f = 0; w_f = 0; b_f = 0; ar_f = 0; r_f = 0; aw_d = 0; w_d = 0; ar_d = 0;
                c_aw = 0; c_w = 0; c_b = 0; c_ar = 0; c_r = 0;
                s_awready = 0; s_wready = 0; s_bvalid = 0; s_arready = 0; s_rvalid = 0;
            end else begin
                if (aw_f) begin s_awready = 0; aw_f = 0; aw_d = 1; c_aw = 0; end
                else if (bus.awvalid && !s_awready) begin
                    if (c_aw >= lat_aw) s_awready = 1; else c_aw++;
                end
                if (bus.awvalid && s_awready) begin aw_f = 1; a_aw = bus.awaddr; end

                if (w_f) begin s_wready = 0; w_f = 0; w_d = 1; c_w = 0; end
                else if (bus.wvalid && !s_wready) begin
                    if (c_w >= lat_w) s_wready = 1; else c_w++;
                end
                if (bus.wvalid && s_wready) begin w_f = 1; d_w = bus.wdata; s_w = bus.wstrb; end

                if (b_f) begin s_bvalid = 0; b_f = 0; aw_d = 0; w_d = 0; c_b = 0; end
                else if (aw_d && w_d && !s_bvalid) begin
                    if (c_b >= lat_b) begin
                        s_bvalid = 1;
                        s_bresp  = cfg_resp;
                        cur = slv_mem.exists(a_aw) ? slv_mem[a_aw] : 32'h0;
                        for (int i = 0; i < 4; i++) if (s_w[i]) cur[8*i +: 8] = d_w[8*i +: 8];
                        slv_mem[a_aw] = cur;
                    end else c_b++;
                end
                if (s_bvalid && bus.bready) b_f = 1;

                if (ar_f) begin s_arready = 0; ar_f = 0; ar_d = 1; c_ar = 0; end
                else if (bus.arvalid && !s_arready) begin
                    if (c_ar >= lat_ar) s_arready = 1; else c_ar++;
                end
                if (bus.arvalid && s_arready) begin ar_f = 1; a_ar = bus.araddr; end

                if (r_f) begin s_rvalid = 0; r_f = 0; ar_d = 0; c_r = 0; end
                else if (ar_d && !s_rvalid) begin
                    if (c_r >= lat_r) begin
                        s_rvalid = 1;
                        s_rresp  = cfg_resp;
                        s_rdata  = slv_mem.exists(a_ar) ? slv_mem[a_ar] : 32'h0;
                    end else c_r++;
                end
                if (s_rvalid && bus.rready) r_f = 1;
            end
        end
    end

    // Per-cycle protocol expectations given which handshakes have already completed.
    task automatic check_cycle(input bit wr, input bit aw_h, input bit w_h, input bit b_h,
                               input bit ar_h, input bit r_h, input logic [31:0] a,
                               input logic [31:0] d, input logic [3:0] s);
        chk("awvalid", 32'(bus.awvalid), 32'(wr && !aw_h));
        chk("wvalid", 32'(bus.wvalid), 32'(wr && !w_h));
        chk("bready", 32'(bus.bready), 32'(wr && aw_h && w_h && !b_h));
        chk("arvalid", 32'(bus.arvalid), 32'(!wr && !ar_h));
        chk("rready", 32'(bus.rready), 32'(!wr && ar_h && !r_h));
        chk("rsp_valid", 32'(rsp_valid), 32'(wr ? b_h : r_h));
        chk("busy", 32'(busy), 32'd1);
        chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
        chk("prot", 32'({bus.awprot, bus.arprot}), 32'd0);
        if (bus.awvalid) chk("awaddr", bus.awaddr, a);
        if (bus.wvalid) begin
            chk("wdata", bus.wdata, d);
            chk("wstrb", 32'(bus.wstrb), 32'(s));
        end
        if (bus.arvalid) chk("araddr", bus.araddr, a);
    endtask

    task automatic do_cmd(input bit wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int awl, input int wl, input int bl,
                          input int arl, input int rl, input logic [1:0] resp, input int hold);
        logic [31:0] exp_rdata;
        int exp_lat, c;
        bit aw_h, w_h, b_h, ar_h, r_h;
        lat_aw = awl; lat_w = wl; lat_b = bl; lat_ar = arl; lat_r = rl; cfg_resp = resp;
        exp_rdata = wr ? 32'h0 : ref_read(a);
        exp_lat   = wr ? 3 + ((awl > wl) ? awl : wl) + bl : 3 + arl + rl;
        c = 0;
        while (cmd_ready !== 1'b1 && c < 50) begin step(); c++; end
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1; cmd_wr = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        aw_h = 0; w_h = 0; b_h = 0; ar_h = 0; r_h = 0; c = 0;
        do begin
            step();
            c++;
            cmd_valid = 0; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
            check_cycle(wr, aw_h, w_h, b_h, ar_h, r_h, a, d, s);
            aw_h = aw_h | (bus.awvalid && bus.awready);
            w_h  = w_h  | (bus.wvalid && bus.wready);
            b_h  = b_h  | (bus.bvalid && bus.bready);
            ar_h = ar_h | (bus.arvalid && bus.arready);
            r_h  = r_h  | (bus.rvalid && bus.rready);
        end while (rsp_valid !== 1'b1 && c < 100);
        chk("rsp_latency", 32'(c), 32'(exp_lat));
        chk("rsp_wr", 32'(rsp_wr), 32'(wr));
        chk("rsp_rdata", rsp_rdata, exp_rdata);
        chk("rsp_resp", 32'(rsp_resp), 32'(resp));
        for (int i = 0; i < hold; i++) begin
            step();
            check_cycle(wr, aw_h, w_h, b_h, ar_h, r_h, a, d, s);
            chk("hold_rdata", rsp_rdata, exp_rdata);
            chk("hold_resp", 32'(rsp_resp), 32'(resp));
            chk("hold_wr", 32'(rsp_wr), 32'(wr));
        end
        rsp_ready = 1;
        step();
        rsp_ready = 0;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        if (wr) ref_write(a, d, s);
        last_rdata = exp_rdata; last_resp = resp; last_wr = wr;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        bit wr;
        // reset values while rst is held
        repeat (3) step();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_valids", 32'({bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}), 32'd0);
        chk("rst_payload", rsp_rdata | 32'(rsp_resp) | 32'(rsp_wr), 32'd0);
        rst = 0;
        #1;
        chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // zero-wait write of 1 to 0x04
        do_cmd(1, 32'h04, 32'h0000_0001, 4'hF, 0, 0, 0, 0, 0, 2'b00, 0);
        // W accepted three cycles before AW, and the reverse
        do_cmd(1, 32'h10, 32'hA5A5_5A5A, 4'hF, 3, 0, 1, 0, 0, 2'b00, 0);
        do_cmd(1, 32'h14, 32'h1357_9BDF, 4'h5, 0, 2, 0, 0, 0, 2'b00, 0);
        // read back with 5 wait cycles on rvalid
        do_cmd(1, 32'h08, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00, 0);
        do_cmd(0, 32'h08, 32'h0, 4'h0, 0, 0, 0, 0, 5, 2'b00, 0);
        do_cmd(0, 32'h04, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 0);
        // host backpressure on the response
        do_cmd(0, 32'h10, 32'h0, 4'h0, 0, 0, 0, 2, 1, 2'b00, 10);
        // error responses pass through
        do_cmd(1, 32'h0C, 32'h0000_00FF, 4'h1, 0, 0, 0, 0, 0, 2'b10, 0);
        do_cmd(0, 32'h1C, 32'h0, 4'h0, 0, 0, 0, 1, 0, 2'b11, 0);

        // stray B and R beats while idle change nothing
        spur_rdata = 32'h1234_5678; spur_bvalid = 1; spur_rvalid = 1;
        repeat (3) begin
            step();
            chk("spur_busy", 32'(busy), 32'd0);
            chk("spur_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("spur_rdata", rsp_rdata, last_rdata);
            chk("spur_resp", 32'(rsp_resp), 32'(last_resp));
            chk("spur_wr", 32'(rsp_wr), 32'(last_wr));
        end
        spur_bvalid = 0; spur_rvalid = 0;
        step();

        // reset while waiting for read data
        lat_ar = 0; lat_r = 8; cfg_resp = 2'b00;
        chk("pre_rd_cmd_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1; cmd_wr = 0; cmd_addr = 32'h08;
        step();
        cmd_valid = 0;
        step();
        chk("rd_data_rready", 32'(bus.rready), 32'd1);
        rst = 1;
        #1;
        chk("mid_rst_valids", 32'({bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("mid_rst_rsp", rsp_rdata | 32'(rsp_resp) | 32'({rsp_wr, rsp_valid}), 32'd0);
        step();
        step();
        rst = 0;
        #1;
        chk("mid_rst_release", 32'(cmd_ready), 32'd1);
        step();
        chk("mid_rst_no_rsp", 32'({rsp_valid, busy}), 32'd0);
        last_rdata = 0; last_resp = 0; last_wr = 0;
        do_cmd(1, 32'h18, 32'hCAFE_F00D, 4'hF, 0, 0, 0, 0, 0, 2'b00, 0);
        do_cmd(0, 32'h18, 32'h0, 4'h0, 1, 1, 1, 1, 1, 2'b00, 1);

        // randomized traffic over a small address window
        for (int n = 0; n < 40; n++) begin
            wr = 1'($urandom);
            do_cmd(wr, 32'($urandom_range(0, 7) * 4), $urandom, 4'($urandom),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3),
                   2'($urandom_range(0, 3)), $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
